// File: rtl/calc_pkg.sv
// Shared calculator-datapath definitions: FSM encoding, op encoding and
// default operand geometry used by the add/sub unit and its neighbours.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIGIT = 4;

endpackage

// File: rtl/addsub_serial_unit_digit_adder.sv
// Combinational DIGIT-bit ripple slice; c_msb is the carry entering the top
// bit of the slice, recovered from the sum and operand bits at that position.
module digit_adder
    import calc_pkg::*;
#(
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign sum   = full[DIGIT-1:0];
    assign cout  = full[DIGIT];
    assign c_msb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/addsub_serial_unit.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module addsub_serial_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output state_t           state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             run_c;
    logic             op_q;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;
    logic             last;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x     (a_sr[DIGIT-1:0]),
        .y     (b_sr[DIGIT-1:0]),
        .cin   (run_c),
        .sum   (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    // New digit enters at the MSB end so the word is aligned after N shifts.
    assign acc_next = WIDTH'({dsum, acc} >> DIGIT);
    assign last     = (cnt == CW'(N - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            run_c     <= 1'b0;
            op_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= (op_sub == OP_SUB) ? ~b : b;
                        op_q     <= op_sub;
                        run_c    <= op_sub;
                        cnt      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    acc   <= acc_next;
                    run_c <= dcout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        result    <= acc_next;
                        // Subtract reports borrow, the inverse of the raw carry.
                        carry     <= dcout ^ op_q;
                        ovf       <= dcmsb ^ dcout;
                        zero      <= (acc_next == '0);
                        neg       <= acc_next[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
